// File: rtl/mem_access.sv
// MEM-stage data-bus access unit: issues loads/stores over a req/ack bus,
// stalls the pipeline while outstanding, formats load data for writeback.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_wreg_i      ex_mem writeback bundle {we, addr, data}; data = eff. addr
//   mem_op_i        memory op code (0 none, 1..8 LB..SW, 9..15 none)
//   mem_sdata_i     store data
//   hold_i          downstream hold; keeps the finished access presented
//   dbus_*          data bus request/response
//   stallreq_o      stall request while an access is outstanding
//   misalign_o      pulse on misaligned half/word access
//   bus_err_o       pulse on bus timeout
//   mem_wreg_o      writeback bundle to mem_wb

package mem_pkg;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } reg_t;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

endpackage

module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  reg_t        mem_wreg_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_sdata_i,
  input  logic        hold_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output reg_t        mem_wreg_o
);

  localparam int unsigned CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  // op decode of the incoming instruction
  logic is_ld, is_st, is_sgn;
  logic sz_b, sz_h, sz_w;
  logic is_mem, mis, go;
  logic [31:0] ea;
  logic [3:0]  be_c;
  logic [31:0] wd_c;

  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_sgn = 1'b0;
    sz_b   = 1'b0;
    sz_h   = 1'b0;
    sz_w   = 1'b0;
    case (mem_op_i)
      OP_LB: begin
        is_ld = 1'b1; is_sgn = 1'b1; sz_b = 1'b1;
      end
      OP_LBU: begin
        is_ld = 1'b1; sz_b = 1'b1;
      end
      OP_LH: begin
        is_ld = 1'b1; is_sgn = 1'b1; sz_h = 1'b1;
      end
      OP_LHU: begin
        is_ld = 1'b1; sz_h = 1'b1;
      end
      OP_LW: begin
        is_ld = 1'b1; sz_w = 1'b1;
      end
      OP_SB: begin
        is_st = 1'b1; sz_b = 1'b1;
      end
      OP_SH: begin
        is_st = 1'b1; sz_h = 1'b1;
      end
      OP_SW: begin
        is_st = 1'b1; sz_w = 1'b1;
      end
      default: ;
    endcase
  end

  assign ea     = mem_wreg_i.data;
  assign is_mem = is_ld | is_st;
  assign mis    = (sz_h & ea[0]) |
                  (sz_w & (ea[1:0] != 2'b00));
  assign go     = is_mem & ~mis;

  always_comb begin
    be_c = 4'b0000;
    wd_c = mem_sdata_i;
    unique case (1'b1)
      sz_b: begin
        be_c = 4'b0001 << ea[1:0];
        wd_c = {4{mem_sdata_i[7:0]}};
      end
      sz_h: begin
        be_c = ea[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{mem_sdata_i[15:0]}};
      end
      sz_w: begin
        be_c = 4'b1111;
        wd_c = mem_sdata_i;
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] fmt_load(
    input logic [31:0] rd,
    input logic [1:0]  a,
    input logic        b,
    input logic        h,
    input logic        s
  );
    logic [7:0]  by;
    logic [15:0] hw;
    case (a)
      2'd0:    by = rd[7:0];
      2'd1:    by = rd[15:8];
      2'd2:    by = rd[23:16];
      default: by = rd[31:24];
    endcase
    hw = a[1] ? rd[31:16] : rd[15:0];
    if (b)
      fmt_load = s ? {{24{by[7]}}, by}
                   : {24'd0, by};
    else if (h)
      fmt_load = s ? {{16{hw[15]}}, hw}
                   : {16'd0, hw};
    else
      fmt_load = rd;
  endfunction

  // state and the access latched on issue
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] ldata_q, ldata_d;
  logic        err_q, err_d;
  logic        ld_q, ld_d;
  logic        sgn_q, sgn_d;
  logic        szb_q, szb_d;
  logic        szh_q, szh_d;
  logic        bwe_q, bwe_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  reg_t        wreg_q, wreg_d;
  logic        cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ldata_d = ldata_q;
    err_d   = err_q;
    ld_d    = ld_q;
    sgn_d   = sgn_q;
    szb_d   = szb_q;
    szh_d   = szh_q;
    bwe_d   = bwe_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          ldata_d = '0;
          err_d   = 1'b0;
          ld_d    = is_ld;
          sgn_d   = is_sgn;
          szb_d   = sz_b;
          szh_d   = sz_h;
          bwe_d   = is_st;
          addr_d  = {ea[31:2], 2'b00};
          be_d    = be_c;
          wd_d    = wd_c;
          wreg_d  = mem_wreg_i;
        end
      end
      S_WAIT: begin
        // ack takes priority over timeout
        if (dbus_ack_i) begin
          ldata_d = fmt_load(dbus_rdata_i,
                             wreg_q.data[1:0],
                             szb_q, szh_q, sgn_q);
          state_d = S_DONE;
        end else if (cnt_last) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!hold_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ldata_q <= '0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      sgn_q   <= 1'b0;
      szb_q   <= 1'b0;
      szh_q   <= 1'b0;
      bwe_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      wreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      sgn_q   <= sgn_d;
      szb_q   <= szb_d;
      szh_q   <= szh_d;
      bwe_q   <= bwe_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
    end
  end

  // outputs are forced low while reset is asserted
  always_comb begin
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_be_o    = '0;
    dbus_wdata_o = '0;
    stallreq_o   = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    mem_wreg_o   = '0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          mem_wreg_o = mem_wreg_i;
          if (is_mem)
            mem_wreg_o.we = 1'b0;
          misalign_o = is_mem & mis;
          if (go) begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = is_st;
            dbus_addr_o  = {ea[31:2], 2'b00};
            dbus_be_o    = be_c;
            dbus_wdata_o = wd_c;
            stallreq_o   = 1'b1;
          end
        end
        S_WAIT: begin
          stallreq_o    = 1'b1;
          mem_wreg_o    = wreg_q;
          mem_wreg_o.we = 1'b0;
          bus_err_o     = cnt_last & ~dbus_ack_i;
          if (!cnt_last) begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = bwe_q;
            dbus_addr_o  = addr_q;
            dbus_be_o    = be_q;
            dbus_wdata_o = wd_q;
          end
        end
        S_DONE: begin
          mem_wreg_o    = wreg_q;
          mem_wreg_o.we = wreg_q.we & ld_q & ~err_q;
          if (ld_q)
            mem_wreg_o.data = ldata_q;
        end
        default: ;
      endcase
    end
  end

endmodule
